// File: rtl/ma_stage.sv
// rtl/ma_stage.sv - memory-access pipeline stage: holds one instruction, extracts load data, feeds writeback and forwarding
module ma_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_validout,
  input  logic [73:0] ex_to_ma_bus,
  input  logic [31:0] data_sram_rdata,
  input  logic        wb_allowin,
  output logic        ma_allowin,
  output logic        ma_validout,
  output logic [69:0] ma_to_wb_bus,
  output logic [37:0] ma_fwd_bus
);

  localparam logic ready_go = 1'b1;

  logic        valid_q, valid_d;
  logic [73:0] bus_q, bus_d;

  logic        res_from_mem;
  logic [2:0]  load_type;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] final_result;

  assign res_from_mem = bus_q[73];
  assign load_type    = bus_q[72:70];
  assign gr_we        = bus_q[69];
  assign dest         = bus_q[68:64];
  assign alu_result   = bus_q[63:32];
  assign pc           = bus_q[31:0];

  assign ma_allowin  = ~valid_q | (ready_go & wb_allowin);
  assign ma_validout = valid_q & ready_go;

  always_comb begin
    valid_d = valid_q;
    bus_d   = bus_q;
    if (ma_allowin) begin
      valid_d = ex_validout;
    end
    if (ex_validout && ma_allowin) begin
      bus_d = ex_to_ma_bus;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      bus_q   <= 74'b0;
    end else begin
      valid_q <= valid_d;
      bus_q   <= bus_d;
    end
  end

  // SRAM read data is used combinationally; it stays stable while stalled
  always_comb begin
    byte_sel = 8'b0;
    half_sel = 16'b0;
    case (alu_result[1:0])
      2'b00:   byte_sel = data_sram_rdata[7:0];
      2'b01:   byte_sel = data_sram_rdata[15:8];
      2'b10:   byte_sel = data_sram_rdata[23:16];
      default: byte_sel = data_sram_rdata[31:24];
    endcase
    half_sel = alu_result[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
  end

  always_comb begin
    load_data = data_sram_rdata;
    case (load_type)
      3'b001:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b010:  load_data = {24'b0, byte_sel};
      3'b011:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {16'b0, half_sel};
      default: load_data = data_sram_rdata;
    endcase
  end

  assign final_result = res_from_mem ? load_data : alu_result;

  // gr_we goes to writeback raw; only the forwarding copy is qualified by valid
  assign ma_to_wb_bus = {gr_we, dest, final_result, pc};
  assign ma_fwd_bus   = {gr_we & valid_q, dest, final_result};

endmodule

// File: tb/tb_ma_stage.sv
// tb/tb_ma_stage.sv - self-checking bench for ma_stage: vector table, corner sequences, randomized model compare
module tb_ma_stage;

  logic        clk;
  logic        rst;
  logic        ex_validout;
  logic [73:0] ex_to_ma_bus;
  logic [31:0] data_sram_rdata;
  logic        wb_allowin;
  logic        ma_allowin;
  logic        ma_validout;
  logic [69:0] ma_to_wb_bus;
  logic [37:0] ma_fwd_bus;

  int n_checks = 0;
  int n_fail   = 0;

  logic        m_valid = 1'b0;
  logic [73:0] m_bus   = 74'b0;

  ma_stage dut (
    .clk             (clk),
    .rst             (rst),
    .ex_validout     (ex_validout),
    .ex_to_ma_bus    (ex_to_ma_bus),
    .data_sram_rdata (data_sram_rdata),
    .wb_allowin      (wb_allowin),
    .ma_allowin      (ma_allowin),
    .ma_validout     (ma_validout),
    .ma_to_wb_bus    (ma_to_wb_bus),
    .ma_fwd_bus      (ma_fwd_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rfm;
    logic [2:0]  lt;
    logic        we;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [73:0] mkbus(input logic rfm, input logic [2:0] lt, input logic we,
                                        input logic [4:0] dest, input logic [31:0] alu, input logic [31:0] pc);
    return {rfm, lt, we, dest, alu, pc};
  endfunction

  // Reference load result computed arithmetically from the load rules
  function automatic logic [31:0] ref_result(input logic [73:0] bus, input logic [31:0] rdata);
    logic [31:0] alu;
    int unsigned b, h;
    alu = bus[63:32];
    if (!bus[73]) return alu;
    b = (rdata >> (8 * alu[1:0])) & 32'hFF;
    h = (rdata >> (16 * alu[1])) & 32'hFFFF;
    case (bus[72:70])
      3'd1:    return (b >= 128) ? b - 256 : b;
      3'd2:    return b;
      3'd3:    return (h >= 32768) ? h - 65536 : h;
      3'd4:    return h;
      default: return rdata;
    endcase
  endfunction

  task automatic chk(input string name, input logic [73:0] act, input logic [73:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ev, input logic [73:0] bus, input logic [31:0] rd, input logic wb);
    ex_validout     = ev;
    ex_to_ma_bus    = bus;
    data_sram_rdata = rd;
    wb_allowin      = wb;
  endtask

  // Advance one clock, updating the model from the inputs present at the edge
  task automatic cycle();
    logic allow;
    @(posedge clk);
    if (rst) begin
      allow = !m_valid || wb_allowin;
      if (allow && ex_validout) m_bus = ex_to_ma_bus;
      if (allow) m_valid = ex_validout;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [31:0] res;
    res = ref_result(m_bus, data_sram_rdata);
    chk({tag, "_validout"}, {73'b0, ma_validout}, {73'b0, m_valid});
    chk({tag, "_allowin"}, {73'b0, ma_allowin}, {73'b0, !m_valid || wb_allowin});
    chk({tag, "_wb_bus"}, {4'b0, ma_to_wb_bus}, {4'b0, m_bus[69], m_bus[68:64], res, m_bus[31:0]});
    chk({tag, "_fwd_bus"}, {36'b0, ma_fwd_bus}, {36'b0, m_bus[69] & m_valid, m_bus[68:64], res});
  endtask

  initial begin
    logic [73:0] bus_a, bus_b, rbus;
    logic [31:0] rrd;

    vecs[0]  = '{1'b0, 3'd0, 1'b1, 5'd5, 32'h12345678, 32'h1C000000, 32'hDEADBEEF, 32'h12345678};
    vecs[1]  = '{1'b1, 3'd1, 1'b1, 5'd3, 32'h00001003, 32'h1C000004, 32'h80FF7F01, 32'hFFFFFF80};
    vecs[2]  = '{1'b1, 3'd2, 1'b1, 5'd4, 32'h00001003, 32'h1C000008, 32'h80FF7F01, 32'h00000080};
    vecs[3]  = '{1'b1, 3'd3, 1'b1, 5'd6, 32'h00001000, 32'h1C00000C, 32'h80FF7F01, 32'h00007F01};
    vecs[4]  = '{1'b1, 3'd3, 1'b1, 5'd7, 32'h00001002, 32'h1C000010, 32'h80FF7F01, 32'hFFFF80FF};
    vecs[5]  = '{1'b1, 3'd4, 1'b1, 5'd8, 32'h00001002, 32'h1C000014, 32'h80FF7F01, 32'h000080FF};
    vecs[6]  = '{1'b1, 3'd0, 1'b1, 5'd9, 32'h00001001, 32'h1C000018, 32'h80FF7F01, 32'h80FF7F01};
    vecs[7]  = '{1'b1, 3'd7, 1'b0, 5'd10, 32'h00001002, 32'h1C00001C, 32'h80FF7F01, 32'h80FF7F01};
    vecs[8]  = '{1'b1, 3'd1, 1'b1, 5'd11, 32'h00001000, 32'h1C000020, 32'h80FF7F01, 32'h00000001};
    vecs[9]  = '{1'b1, 3'd3, 1'b1, 5'd12, 32'h00001003, 32'h1C000024, 32'h80FF7F01, 32'hFFFF80FF};
    vecs[10] = '{1'b1, 3'd1, 1'b1, 5'd13, 32'h00001001, 32'h1C000028, 32'h80FF7F01, 32'h0000007F};

    rst = 1'b0;
    drive(1'b0, 74'b0, 32'b0, 1'b1);
    #1;
    chk("reset_validout", {73'b0, ma_validout}, 74'd0);
    chk("reset_allowin", {73'b0, ma_allowin}, 74'd1);
    chk("reset_wb_bus", {4'b0, ma_to_wb_bus}, 74'd0);
    chk("reset_fwd_bus", {36'b0, ma_fwd_bus}, 74'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;

    for (int i = 0; i < 11; i++) begin
      drive(1'b1, mkbus(vecs[i].rfm, vecs[i].lt, vecs[i].we, vecs[i].dest, vecs[i].alu, vecs[i].pc),
            32'h0, 1'b1);
      cycle();
      drive(1'b0, 74'b0, vecs[i].rdata, 1'b1);
      #1;
      chk($sformatf("vec%0d_validout", i), {73'b0, ma_validout}, 74'd1);
      chk($sformatf("vec%0d_wb_bus", i), {4'b0, ma_to_wb_bus},
          {4'b0, vecs[i].we, vecs[i].dest, vecs[i].exp_res, vecs[i].pc});
      chk($sformatf("vec%0d_fwd_bus", i), {36'b0, ma_fwd_bus},
          {36'b0, vecs[i].we, vecs[i].dest, vecs[i].exp_res});
    end

    // bubble
    drive(1'b0, 74'b0, 32'h0, 1'b1);
    cycle();
    chk("bubble_validout", {73'b0, ma_validout}, 74'd0);
    chk("bubble_fwd_we", {73'b0, ma_fwd_bus[37]}, 74'd0);

    // stall for three cycles with a changing upstream bus, then release
    bus_a = mkbus(1'b0, 3'd0, 1'b1, 5'd5, 32'h12345678, 32'h1C000000);
    drive(1'b1, bus_a, 32'h0, 1'b1);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mkbus(1'b0, 3'd0, 1'b1, 5'(20 + i), 32'hA0000000 + i, 32'h1C000100 + i), 32'h0, 1'b0);
      #1;
      chk($sformatf("stall%0d_allowin", i), {73'b0, ma_allowin}, 74'd0);
      chk($sformatf("stall%0d_wb_bus", i), {4'b0, ma_to_wb_bus},
          {4'b0, 1'b1, 5'd5, 32'h12345678, 32'h1C000000});
      cycle();
    end
    bus_b = mkbus(1'b0, 3'd0, 1'b1, 5'd17, 32'hCAFEF00D, 32'h1C000200);
    drive(1'b1, bus_b, 32'h0, 1'b1);
    #1;
    chk("release_allowin", {73'b0, ma_allowin}, 74'd1);
    cycle();
    chk("release_wb_bus", {4'b0, ma_to_wb_bus}, {4'b0, 1'b1, 5'd17, 32'hCAFEF00D, 32'h1C000200});

    // asynchronous reset between edges while valid
    drive(1'b0, 74'b0, 32'h0, 1'b1);
    #2;
    rst = 1'b0;
    m_valid = 1'b0;
    m_bus   = 74'b0;
    #1;
    chk("async_validout", {73'b0, ma_validout}, 74'd0);
    chk("async_wb_bus", {4'b0, ma_to_wb_bus}, 74'd0);
    chk("async_allowin", {73'b0, ma_allowin}, 74'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;

    // reset released in the middle of a stall
    drive(1'b1, bus_a, 32'h0, 1'b1);
    cycle();
    drive(1'b0, 74'b0, 32'h0, 1'b0);
    cycle();
    rst = 1'b0;
    m_valid = 1'b0;
    m_bus   = 74'b0;
    #2;
    rst = 1'b1;
    cycle();
    chk("stall_reset_validout", {73'b0, ma_validout}, 74'd0);
    chk("stall_reset_fwd_bus", {36'b0, ma_fwd_bus}, 74'd0);

    // randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      rbus = {$urandom, $urandom, $urandom};
      rrd  = $urandom;
      drive(1'($urandom_range(0, 3) != 0), rbus, rrd, 1'($urandom_range(0, 2) != 0));
      #1;
      check_model("rand");
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ma_stage.md
MA_STAGE -- requirements
Module: ma_stage

Interface
REQ-001 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 The block SHALL have port ex_validout, input, 1, upstream execute stage holds a valid instruction.
REQ-004 The block SHALL have port ex_to_ma_bus, input, 74, packed as res_from_mem[73], load_type[72:70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0].
REQ-005 The block SHALL have port data_sram_rdata, input, 32, synchronous data SRAM read data for the address issued by execute in the previous cycle.
REQ-006 The block SHALL have port wb_allowin, input, 1, writeback stage can accept data this cycle.
REQ-007 The block SHALL have port ma_allowin, output, 1, this stage can accept data this cycle.
REQ-008 The block SHALL have port ma_validout, output, 1, this stage presents a valid instruction to writeback.
REQ-009 The block SHALL have port ma_to_wb_bus, output, 70, packed as gr_we[69], dest[68:64], final_result[63:32], pc[31:0].
REQ-010 The block SHALL have port ma_fwd_bus, output, 38, packed as fwd_we[37], dest[36:32], final_result[31:0], for decode-stage hazard/forwarding.

Function
REQ-011 load_type encoding SHALL be 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; 101-111 SHALL be treated as lw.
REQ-012 The stage SHALL hold a valid flag and a 74-bit bus register.
REQ-013 readygo SHALL be constant 1; no multi-cycle operation inside this stage.
REQ-014 ma_allowin SHALL equal ~valid | (readygo & wb_allowin), combinational.
REQ-015 ma_validout SHALL equal valid & readygo.
REQ-016 On a clock edge with ma_allowin=1, valid SHALL load ex_validout; with ma_allowin=0, valid SHALL hold.
REQ-017 The bus register SHALL load ex_to_ma_bus only when ex_validout & ma_allowin; otherwise it SHALL hold, including across stalls (wb_allowin=0).
REQ-018 Byte select SHALL use alu_result[1:0]: 00->rdata[7:0], 01->[15:8], 10->[23:16], 11->[31:24].
REQ-019 Halfword select SHALL use alu_result[1]: 0->rdata[15:0], 1->rdata[31:16]; alu_result[0] ignored.
REQ-020 lb/lh SHALL sign-extend to 32 bits; lbu/lhu SHALL zero-extend; lw SHALL pass rdata unmodified regardless of alu_result[1:0].
REQ-021 final_result SHALL be the extended load data when res_from_mem=1, else alu_result.
REQ-022 ma_to_wb_bus gr_we SHALL be the registered gr_we unqualified by valid; writeback qualifies it.
REQ-023 fwd_we SHALL equal gr_we & valid; when valid=0, ma_fwd_bus[37] SHALL be 0.
REQ-024 data_sram_rdata SHALL be consumed in the first cycle the instruction is valid in this stage; the upstream stage guarantees an instruction enters only in the cycle after its SRAM request.
REQ-025 When wb_allowin=0 with valid=1, all outputs SHALL remain stable except final_result for loads, which tracks data_sram_rdata (the SRAM holds output when no new request).
REQ-026 With ma_allowin=1 and ex_validout=0, valid SHALL clear on the next edge (bubble inserted).

Reset
REQ-027 While rst=0, valid and the bus register SHALL be cleared to 0 immediately, independent of clk.
REQ-028 During and after reset until first capture: ma_validout=0, ma_allowin=1, ma_to_wb_bus=70'b0, ma_fwd_bus=38'b0.
REQ-029 Reset deassertion mid-stall SHALL leave no residual valid instruction.

Verification
REQ-030 Pass-through: ex_validout=1, res_from_mem=0, gr_we=1, dest=5, alu_result=0x12345678, pc=0x1C000000, wb_allowin=1 -> next cycle ma_validout=1, ma_to_wb_bus={1,5,0x12345678,0x1C000000}, ma_fwd_bus={1,5,0x12345678}.
REQ-031 Loads with rdata=0x80FF7F01: lb addr[1:0]=11 -> 0xFFFFFF80; lbu 11 -> 0x00000080; lh addr[1]=0 -> 0x00007F01; lh addr[1]=1 -> 0xFFFF80FF; lhu 1 -> 0x000080FF; lw addr 01 -> 0x80FF7F01.
REQ-032 Stall: valid=1, wb_allowin=0 for 3 cycles with ex_validout=1 and changing bus -> ma_allowin=0, ma_to_wb_bus unchanged; on release next edge captures the new bus.
REQ-033 Bubble: wb_allowin=1, ex_validout=0 -> ma_validout=0 next cycle, ma_fwd_bus[37]=0.
REQ-034 Async reset: drive rst=0 between clock edges while valid=1 -> ma_validout=0 and ma_to_wb_bus=0 before next edge; ma_allowin=1.
